// File: rtl/fifo_ctrl_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_ctrl_sync_pkg
// Brief   : Shared types and helpers for the single-clock FIFO controller:
//           FWFT read-side state encoding, clog2 helper and pointer-compare
//           macros.
// Revision: 1.0 - initial release
// ============================================================================

// Pointer compare helpers. Arguments must be plain identifiers so they can
// be bit-selected. Pointers are ADDR_WIDTH+1 bits wide; the extra MSB is
// the wrap bit.
`ifndef FIFO_CTRL_SYNC_PTR_MACROS
`define FIFO_CTRL_SYNC_PTR_MACROS
`define FIFO_PTR_FULL(wp, rp, aw)  ((wp[aw] != rp[aw]) && (wp[aw-1:0] == rp[aw-1:0]))
`define FIFO_PTR_EMPTY(wp, rp)     (wp == rp)
`endif

package fifo_ctrl_sync_pkg;

    // First-word-fall-through read-side states
    typedef enum logic [1:0] {
        FWFT_IDLE  = 2'd0,  // nothing presented, RAM empty or not yet seen
        FWFT_FILL  = 2'd1,  // RAM read in flight for the head word
        FWFT_VALID = 2'd2   // head word sits on the RAM output
    } fwft_state_e;

    // Ceiling log2 for elaboration-time sizing
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : fifo_ctrl_sync_pkg

`default_nettype wire

// File: rtl/fifo_ctrl_sync_fwft.sv
`default_nettype none
// ============================================================================
// Module  : fifo_ctrl_sync_fwft
// Brief   : First-word-fall-through read sequencer. Pre-fetches the head word
//           from the synchronous-read RAM so it is visible before rd_en, and
//           re-fetches on every consume while words remain.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_ctrl_sync_fwft
    import fifo_ctrl_sync_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic rd_en,      // consume the presented word
    input  logic ram_empty,  // no unread words left in the RAM
    output logic rd_mem_en,  // RAM read strobe (also advances rd_ptr)
    output logic rd_valid,   // presented word valid on RAM output
    output logic hold_d      // next cycle a word is held outside the RAM
);

    fwft_state_e state_q;
    fwft_state_e state_d;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= FWFT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and RAM read strobe
    always_comb begin
        state_d   = state_q;
        rd_mem_en = 1'b0;
        case (state_q)
            FWFT_IDLE: begin
                if (!ram_empty) begin
                    state_d = FWFT_FILL;
                end
            end
            FWFT_FILL: begin
                // Only this sequencer reads, so the RAM cannot have drained
                rd_mem_en = 1'b1;
                state_d   = FWFT_VALID;
            end
            FWFT_VALID: begin
                if (rd_en) begin
                    if (!ram_empty) begin
                        rd_mem_en = 1'b1;   // replace consumed word
                    end else begin
                        state_d = FWFT_IDLE;
                    end
                end
            end
            default: begin
                state_d = FWFT_IDLE;
            end
        endcase
    end

    assign rd_valid = (state_q == FWFT_VALID);
    assign hold_d   = (state_d == FWFT_VALID);

endmodule : fifo_ctrl_sync_fwft

`default_nettype wire

// File: rtl/fifo_ctrl_sync.sv
`default_nettype none
// ============================================================================
// Module  : fifo_ctrl_sync
// Brief   : Single-clock FIFO pointer/flag controller for an external simple
//           dual-port RAM with 1-cycle synchronous read. All FIFO_DEPTH
//           entries usable, registered flags, exact occupancy count and
//           selectable standard / first-word-fall-through read.
//           Optional sticky overflow/underflow flags: FIFO_CTRL_SYNC_ERR_EN.
//           rstn asserts asynchronously; its release is expected to be
//           synchronous to clk.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_ctrl_sync
    import fifo_ctrl_sync_pkg::*;
#(
    parameter int FIFO_DEPTH    = 256,
    parameter int ADDR_WIDTH    = clog2(FIFO_DEPTH),
    parameter int FWFT          = 0,
    parameter int ACK_ENA       = 0,
    parameter int AFULL_THRESH  = 240,
    parameter int AEMPTY_THRESH = 16
)
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_mem_en,
    output logic                  wr_ack,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_mem_en,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          ram_empty_q, ram_empty_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;
    logic          wr_accept;
    logic          hold_d;

    // Writes are refused while full even if a read happens the same cycle
    assign wr_accept = wr_en & ~full_q;
    assign wr_mem_en = wr_accept;
    assign wr_addr   = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_addr   = rd_ptr_q[ADDR_WIDTH-1:0];

    // Next pointers, occupancy and flags, all derived from next-state values
    always_comb begin
        wr_ptr_d    = wr_ptr_q + PW'(wr_accept);
        rd_ptr_d    = rd_ptr_q + PW'(rd_mem_en);
        count_d     = (wr_ptr_d - rd_ptr_d) + PW'(hold_d);
        full_d      = `FIFO_PTR_FULL(wr_ptr_d, rd_ptr_d, ADDR_WIDTH);
        ram_empty_d = `FIFO_PTR_EMPTY(wr_ptr_d, rd_ptr_d);
        afull_d     = (count_d >= PW'(AFULL_THRESH));
        aempty_d    = (count_d <= PW'(AEMPTY_THRESH));
    end

    // Pointer, count and flag registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            ram_empty_q <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            ram_empty_q <= ram_empty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
        end
    end

    assign full         = full_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign data_count   = count_q;

    generate
        if (FWFT != 0) begin : g_fwft
            fifo_ctrl_sync_fwft u_fwft (
                .clk       (clk),
                .rstn      (rstn),
                .rd_en     (rd_en),
                .ram_empty (ram_empty_q),
                .rd_mem_en (rd_mem_en),
                .rd_valid  (rd_valid),
                .hold_d    (hold_d)
            );
            assign empty = ~rd_valid;
        end else begin : g_std
            logic rd_valid_q;

            // A read on an empty RAM is dropped, even alongside a write
            assign rd_mem_en = rd_en & ~ram_empty_q;
            assign hold_d    = 1'b0;

            // RAM output is valid the cycle after an accepted read
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_mem_en;
                end
            end

            assign rd_valid = rd_valid_q;
            assign empty    = ram_empty_q;
        end
    endgenerate

    generate
        if (ACK_ENA != 0) begin : g_ack
            logic wr_ack_q;

            // Acknowledge accepted writes one cycle later
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    wr_ack_q <= 1'b0;
                end else begin
                    wr_ack_q <= wr_accept;
                end
            end

            assign wr_ack = wr_ack_q;
        end else begin : g_no_ack
            assign wr_ack = 1'b0;
        end
    endgenerate

`ifdef FIFO_CTRL_SYNC_ERR_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky error flags; empty already means "nothing presented" in FWFT
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q  | (wr_en & full_q);
            underflow_q <= underflow_q | (rd_en & empty);
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule : fifo_ctrl_sync

`default_nettype wire

// File: tb/tb_fifo_ctrl_sync.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_ctrl_sync
// Brief   : Bench for fifo_ctrl_sync: one standard-read instance (wr_ack on)
//           and one FWFT instance, each with its own RAM, checked against
//           queue-based reference models.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl_sync;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] wdata = '0;

    always #5 clk = ~clk;

    // Standard-read instance
    logic [AW-1:0] s_wr_addr, s_rd_addr;
    logic          s_wr_mem_en, s_wr_ack, s_full, s_afull, s_rd_mem_en, s_rd_valid;
    logic          s_empty, s_aempty, s_ovf, s_udf;
    logic [AW:0]   s_count;

    fifo_ctrl_sync #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW), .FWFT(0), .ACK_ENA(1),
                     .AFULL_THRESH(240), .AEMPTY_THRESH(16)) u_dut_std (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(s_wr_addr), .wr_mem_en(s_wr_mem_en),
        .wr_ack(s_wr_ack), .full(s_full), .almost_full(s_afull), .rd_en(rd_en),
        .rd_addr(s_rd_addr), .rd_mem_en(s_rd_mem_en), .rd_valid(s_rd_valid), .empty(s_empty),
        .almost_empty(s_aempty), .data_count(s_count), .overflow(s_ovf), .underflow(s_udf)
    );

    // FWFT instance
    logic [AW-1:0] f_wr_addr, f_rd_addr;
    logic          f_wr_mem_en, f_wr_ack, f_full, f_afull, f_rd_mem_en, f_rd_valid;
    logic          f_empty, f_aempty, f_ovf, f_udf;
    logic [AW:0]   f_count;

    fifo_ctrl_sync #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW), .FWFT(1), .ACK_ENA(0),
                     .AFULL_THRESH(240), .AEMPTY_THRESH(16)) u_dut_fwft (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(f_wr_addr), .wr_mem_en(f_wr_mem_en),
        .wr_ack(f_wr_ack), .full(f_full), .almost_full(f_afull), .rd_en(rd_en),
        .rd_addr(f_rd_addr), .rd_mem_en(f_rd_mem_en), .rd_valid(f_rd_valid), .empty(f_empty),
        .almost_empty(f_aempty), .data_count(f_count), .overflow(f_ovf), .underflow(f_udf)
    );

    // Simple dual-port RAMs with 1-cycle synchronous read
    logic [15:0] s_mem [DEPTH];
    logic [15:0] f_mem [DEPTH];
    logic [15:0] s_dout, f_dout;

    always @(posedge clk) begin
        if (s_wr_mem_en) s_mem[s_wr_addr] <= wdata;
        if (s_rd_mem_en) s_dout <= s_mem[s_rd_addr];
        if (f_wr_mem_en) f_mem[f_wr_addr] <= wdata;
        if (f_rd_mem_en) f_dout <= f_mem[f_rd_addr];
    end

    // Reference models: standard = plain queue; FWFT = queue of words still
    // in RAM plus one presented word that appears two edges after the RAM
    // becomes non-empty while nothing is presented.
    logic [15:0] sq[$];
    bit          s_rv_m, s_ack_m, s_ovf_m, s_udf_m;
    logic [15:0] s_dat_m;
    logic [15:0] fq[$];
    bit          f_pres, f_arm, f_ovf_m, f_udf_m;
    logic [15:0] f_dat_m;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit wr;
        bit rd;
        bit wme;
        int cnt;
        bit full;
        bit empty;
        bit rv;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sq.delete();
        fq.delete();
        s_rv_m = 0; s_ack_m = 0; s_ovf_m = 0; s_udf_m = 0;
        f_pres = 0; f_arm = 0; f_ovf_m = 0; f_udf_m = 0;
    endtask

    task automatic check_outputs();
        int fc;
        fc = fq.size() + (f_pres ? 1 : 0);
        chk("std rd_valid", s_rd_valid, s_rv_m);
        if (s_rv_m) chk("std data", s_dout, s_dat_m);
        chk("std count", s_count, sq.size());
        chk("std full", s_full, sq.size() == DEPTH);
        chk("std empty", s_empty, sq.size() == 0);
        chk("std almost_full", s_afull, sq.size() >= 240);
        chk("std almost_empty", s_aempty, sq.size() <= 16);
        chk("std wr_ack", s_wr_ack, s_ack_m);
        chk("fwft rd_valid", f_rd_valid, f_pres);
        if (f_pres) chk("fwft data", f_dout, f_dat_m);
        chk("fwft count", f_count, fc);
        chk("fwft full", f_full, fq.size() == DEPTH);
        chk("fwft empty", f_empty, !f_pres);
        chk("fwft almost_full", f_afull, fc >= 240);
        chk("fwft almost_empty", f_aempty, fc <= 16);
        chk("fwft wr_ack", f_wr_ack, 0);
`ifdef FIFO_CTRL_SYNC_ERR_EN
        chk("std overflow", s_ovf, s_ovf_m);
        chk("std underflow", s_udf, s_udf_m);
        chk("fwft overflow", f_ovf, f_ovf_m);
        chk("fwft underflow", f_udf, f_udf_m);
`else
        chk("std overflow", s_ovf, 0);
        chk("std underflow", s_udf, 0);
        chk("fwft overflow", f_ovf, 0);
        chk("fwft underflow", f_udf, 0);
`endif
    endtask

    // One clock cycle: drive at negedge, check strobes, clock, check outputs
    task automatic step(input bit w, input bit r, output bit wme);
        bit s_wacc, s_racc, f_wacc;
        wr_en = w;
        rd_en = r;
        wdata = 16'($urandom);
        #1;
        s_wacc = w && (sq.size() < DEPTH);
        s_racc = r && (sq.size() > 0);
        f_wacc = w && (fq.size() < DEPTH);
        wme = s_wr_mem_en;
        chk("std wr_mem_en", s_wr_mem_en, s_wacc);
        chk("std rd_mem_en", s_rd_mem_en, s_racc);
        chk("fwft wr_mem_en", f_wr_mem_en, f_wacc);
        if (w && sq.size() == DEPTH) s_ovf_m = 1;
        if (r && sq.size() == 0)     s_udf_m = 1;
        if (w && fq.size() == DEPTH) f_ovf_m = 1;
        if (r && !f_pres)            f_udf_m = 1;
        @(posedge clk);
        s_rv_m  = s_racc;
        s_ack_m = s_wacc;
        if (s_racc) s_dat_m = sq.pop_front();
        if (s_wacc) sq.push_back(wdata);
        if (f_pres) begin
            if (r) begin
                if (fq.size() > 0) f_dat_m = fq.pop_front();
                else               f_pres = 0;
            end
        end else if (f_arm) begin
            f_dat_m = fq.pop_front();
            f_pres  = 1;
            f_arm   = 0;
        end else if (fq.size() > 0) begin
            f_arm = 1;
        end
        if (f_wacc) fq.push_back(wdata);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic cyc(input bit w, input bit r);
        bit dummy;
        step(w, r, dummy);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " std rd_valid"}, s_rd_valid, 0);
        chk({tag, " std count"}, s_count, 0);
        chk({tag, " std empty"}, s_empty, 1);
        chk({tag, " std almost_empty"}, s_aempty, 1);
        chk({tag, " std full"}, s_full, 0);
        chk({tag, " std almost_full"}, s_afull, 0);
        chk({tag, " std wr_ack"}, s_wr_ack, 0);
        chk({tag, " std ptrs"}, {s_wr_addr, s_rd_addr}, 0);
        chk({tag, " std err"}, {s_ovf, s_udf}, 0);
        chk({tag, " fwft rd_valid"}, f_rd_valid, 0);
        chk({tag, " fwft count"}, f_count, 0);
        chk({tag, " fwft empty"}, f_empty, 1);
        chk({tag, " fwft almost_empty"}, f_aempty, 1);
        chk({tag, " fwft err"}, {f_ovf, f_udf}, 0);
    endtask

    // Assert reset mid-cycle, check immediately, release at a falling edge
    task automatic apply_reset();
        wr_en = 0;
        rd_en = 0;
        #2;
        rstn = 0;
        #1;
        check_reset_values("async reset");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1;
    endtask

    initial begin
        bit wme;

        tbl[0] = '{wr: 0, rd: 1, wme: 0, cnt: 0, full: 0, empty: 1, rv: 0};
        tbl[1] = '{wr: 1, rd: 1, wme: 1, cnt: 1, full: 0, empty: 0, rv: 0};
        tbl[2] = '{wr: 1, rd: 0, wme: 1, cnt: 2, full: 0, empty: 0, rv: 0};
        tbl[3] = '{wr: 0, rd: 1, wme: 0, cnt: 1, full: 0, empty: 0, rv: 1};
        tbl[4] = '{wr: 1, rd: 1, wme: 1, cnt: 1, full: 0, empty: 0, rv: 1};
        tbl[5] = '{wr: 0, rd: 1, wme: 0, cnt: 0, full: 0, empty: 1, rv: 1};
        tbl[6] = '{wr: 0, rd: 0, wme: 0, cnt: 0, full: 0, empty: 1, rv: 0};
        tbl[7] = '{wr: 0, rd: 1, wme: 0, cnt: 0, full: 0, empty: 1, rv: 0};

        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_values("power-on reset");
        rstn = 1;

        // Directed vectors on the standard-read instance
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].wr, tbl[i].rd, wme);
            chk("tbl wr_mem_en", wme, tbl[i].wme);
            chk("tbl count", s_count, tbl[i].cnt);
            chk("tbl full", s_full, tbl[i].full);
            chk("tbl empty", s_empty, tbl[i].empty);
            chk("tbl rd_valid", s_rd_valid, tbl[i].rv);
        end

        // Fill to full; the write after that must be refused
        for (int i = 0; i < DEPTH; i++) cyc(1, 0);
        chk("fill full", s_full, 1);
        chk("fill count", s_count, DEPTH);
        step(1, 0, wme);
        chk("257th wr_mem_en", wme, 0);
        chk("257th count", s_count, DEPTH);

        // Drain to 5 words, then simultaneous read+write holds the count
        while (sq.size() > 5) cyc(0, 1);
        for (int i = 0; i < 100; i++) begin
            cyc(1, 1);
            chk("steady count", s_count, 5);
            chk("steady rd_valid", s_rd_valid, 1);
        end

        // Reset in the middle of a burst at count 100
        apply_reset();
        for (int i = 0; i < 100; i++) cyc(1, 0);
        cyc(1, 1);
        chk("pre-reset rd_valid", s_rd_valid, 1);
        chk("pre-reset count", s_count, 100);
        apply_reset();
        cyc(0, 0);

        // FWFT single-word latency and consume
        cyc(1, 0);
        chk("fwft t+1 rd_valid", f_rd_valid, 0);
        cyc(0, 0);
        chk("fwft t+1.5 rd_valid", f_rd_valid, 0);
        cyc(0, 0);
        chk("fwft t+2 rd_valid", f_rd_valid, 1);
        chk("fwft t+2 count", f_count, 1);
        cyc(0, 1);
        chk("fwft consume rd_valid", f_rd_valid, 0);
        chk("fwft consume empty", f_empty, 1);
        chk("fwft consume count", f_count, 0);

        // Random streaming with shifting write/read bias
        for (int ph = 0; ph < 16; ph++) begin
            int pw, pr;
            pw = $urandom_range(15, 95);
            pr = $urandom_range(15, 95);
            for (int i = 0; i < 200; i++) begin
                cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_fifo_ctrl_sync

`default_nettype wire
